// File: rtl/mdu_pkg.sv
// Shared CPU constants: multiply/divide op codes and unit latencies.
// Used by the MDU and by the main controller to decode mdOp.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Results are computed at start,
// parked in pend registers and committed when the latency counter expires.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] mdRead
);

    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        div_zero;
    logic        div_ovf;

    assign busy = (cnt != 4'd0);

    // Arithmetic results for a starting operation; overflow and /0 are fenced off.
    always_comb begin
        prod_s   = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        prod_u   = {32'd0, srcA} * {32'd0, srcB};
        div_zero = (srcB == 32'd0);
        div_ovf  = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
        quo_s    = 32'd0;
        rem_s    = 32'd0;
        quo_u    = 32'd0;
        rem_u    = 32'd0;
        if (div_ovf) begin
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
        end else if (!div_zero) begin
            quo_s = $signed(srcA) / $signed(srcB);
            rem_s = $signed(srcA) % $signed(srcB);
        end
        if (!div_zero) begin
            quo_u = srcA / srcB;
            rem_u = srcA % srcB;
        end
    end

    // Start, countdown and commit of HI/LO; starts are dropped while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (start) begin
            case (mdOp)
                MD_MULT: begin
                    {pend_hi, pend_lo} <= prod_s;
                    cnt                <= MUL_LAT;
                end
                MD_MULTU: begin
                    {pend_hi, pend_lo} <= prod_u;
                    cnt                <= MUL_LAT;
                end
                MD_DIV: begin
                    // A zero divisor re-commits the current HI/LO unchanged.
                    pend_hi <= div_zero ? hi : rem_s;
                    pend_lo <= div_zero ? lo : quo_s;
                    cnt     <= DIV_LAT;
                end
                MD_DIVU: begin
                    pend_hi <= div_zero ? hi : rem_u;
                    pend_lo <= div_zero ? lo : quo_u;
                    cnt     <= DIV_LAT;
                end
                MD_MTHI: hi <= srcA;
                MD_MTLO: lo <= srcA;
                default: ;
            endcase
        end
    end

    // Architectural HI/LO read-out for MFHI/MFLO.
    always_comb begin
        mdRead = 32'd0;
        case (mdOp)
            MD_MFHI: mdRead = hi;
            MD_MFLO: mdRead = lo;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against a plain-arithmetic model
// of the architectural HI/LO state and operation latency.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] mdRead;

    int checks;
    int failures;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .mdOp   (mdOp),
        .srcA   (srcA),
        .srcB   (srcB),
        .busy   (busy),
        .mdRead (mdRead)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic read_check(input string tag);
        start = 1'b0;
        mdOp  = MD_MFHI;
        #1 chk({tag, ".hi"}, mdRead, m_hi);
        mdOp = MD_MFLO;
        #1 chk({tag, ".lo"}, mdRead, m_lo);
        mdOp = MD_NONE;
        #1 chk({tag, ".none"}, mdRead, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        int          lat;
        int          n;
        logic [63:0] p;
        longint      q;
        longint      r;
        logic [31:0] n_hi;
        logic [31:0] n_lo;
        lat  = 0;
        n_hi = m_hi;
        n_lo = m_lo;
        @(negedge clk);
        start = 1'b1;
        mdOp  = op;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
        mdOp  = MD_NONE;
        case (op)
            4'd1: begin
                lat = 5;
                q   = longint'($signed(a)) * longint'($signed(b));
                p   = q;
                {n_hi, n_lo} = p;
            end
            4'd2: begin
                lat = 5;
                p   = {32'd0, a} * {32'd0, b};
                {n_hi, n_lo} = p;
            end
            4'd3: begin
                lat = 10;
                if (b != 0) begin
                    q    = longint'($signed(a)) / longint'($signed(b));
                    r    = longint'($signed(a)) % longint'($signed(b));
                    n_lo = q[31:0];
                    n_hi = r[31:0];
                end
            end
            4'd4: begin
                lat = 10;
                if (b != 0) begin
                    n_lo = a / b;
                    n_hi = a % b;
                end
            end
            4'd7: begin
                m_hi = a;
                n_hi = a;
            end
            4'd8: begin
                m_lo = a;
                n_lo = a;
            end
            default: ;
        endcase
        if (lat > 0) begin
            n = 0;
            while (busy && n < 20) begin
                if (poke && n == 1) begin
                    mdOp = MD_MFLO;
                    #1 chk({tag, ".old_lo"}, mdRead, m_lo);
                    start = 1'b1;
                    mdOp  = MD_MTLO;
                    srcA  = $urandom;
                end else if (poke && n == 2) begin
                    start = 1'b1;
                    mdOp  = 4'($urandom_range(1, 8));
                    srcA  = $urandom;
                    srcB  = $urandom;
                end else begin
                    start = 1'b0;
                    mdOp  = MD_NONE;
                end
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            mdOp  = MD_NONE;
            chk({tag, ".lat"}, n, lat);
            m_hi = n_hi;
            m_lo = n_lo;
        end else begin
            chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        end
        read_check(tag);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        checks   = 0;
        failures = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        reset_n  = 1'b0;
        start    = 1'b0;
        mdOp     = MD_NONE;
        srcA     = 32'd0;
        srcB     = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        read_check("rst");
        reset_n = 1'b1;

        run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op("divu", MD_DIVU, 32'd17, 32'd5, 1'b1);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div0", MD_DIV, 32'd1234, 32'd0, 1'b0);
        run_op("divu0", MD_DIVU, 32'd99, 32'd0, 1'b1);
        run_op("mthi", MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        run_op("mtlo", MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
        run_op("multp", MD_MULT, $urandom, $urandom, 1'b1);
        run_op("ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mfhi", MD_MFHI, 32'h5555_5555, 32'd0, 1'b0);
        run_op("op12", 4'd12, 32'h7777_7777, 32'd3, 1'b0);

        @(negedge clk);
        start = 1'b1;
        mdOp  = MD_MULTU;
        srcA  = 32'hFFFF_FFFF;
        srcB  = 32'd2;
        @(negedge clk);
        start = 1'b0;
        mdOp  = MD_NONE;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        #1 chk("arst.busy", {31'd0, busy}, 32'd0);
        read_check("arst");
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("arst.idle", n, 0);
        read_check("arst.after");
        run_op("multu", MD_MULTU, 32'd3, 32'd4, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'd1 + 32'($urandom_range(0, 9));
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op("rnd", op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
